// File: rtl/mem_io_pkg.sv
// Shared address map, stop-sequence states and byte helpers for the memory bus responder.
package mem_io_pkg;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_SEL       = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STOP_PUSH = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } stop_state_t;

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] snap_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; caller guarantees push only when not full or popping in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage array, not reset; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CNT_W'(0));
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: RAM, UART RX/TX window, clock counter and program-stop sequence.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int CNT_W      = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        halted
);

  localparam int FCNT_W = $clog2(TX_DEPTH) + 1;

  logic [7:0]            ram_r [2**RAM_ADDR_W];
  logic [CNT_W-1:0]      counter_r;
  logic [CNT_W-1:0]      snapshot_r;
  stop_state_t           state_r;

  logic [17:0]           addr_s;
  logic [RAM_ADDR_W-1:0] ram_addr_s;
  logic                  io_s;
  logic                  uart_sel_s;
  logic                  clk_sel_s;
  logic                  clk_grp_s;
  logic [7:0]            rd_data_s;
  logic                  unused_s;

  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic [7:0]            fifo_din_s;
  logic [7:0]            fifo_dout_s;
  logic [FCNT_W-1:0]     fifo_count_s;
  logic [FCNT_W-1:0]     count_next_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic                  space_s;
  logic                  drop_s;

  assign addr_s     = cpu_a[17:0];
  assign ram_addr_s = cpu_a[RAM_ADDR_W-1:0];
  assign unused_s   = ^cpu_a[31:18];
  assign io_s       = (addr_s[17:16] == IO_SEL);
  assign uart_sel_s = (addr_s == IO_UART_ADDR);
  assign clk_sel_s  = (addr_s == IO_CLK_ADDR);
  assign clk_grp_s  = (addr_s[17:2] == IO_CLK_ADDR[17:2]);

  assign rx_pop     = !cpu_wr && uart_sel_s && rx_valid;
  assign fifo_pop_s = !fifo_empty_s && tx_ready;
  // A full FIFO still accepts a byte when the transmitter drains one in the same cycle.
  assign space_s    = !fifo_full_s || fifo_pop_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH),
    .CNT_W (FCNT_W)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push_s),
    .pop    (fifo_pop_s),
    .din    (fifo_din_s),
    .dout   (fifo_dout_s),
    .count  (fifo_count_s),
    .empty  (fifo_empty_s),
    .full   (fifo_full_s)
  );

  assign tx_valid     = !fifo_empty_s;
  assign tx_data      = fifo_dout_s;
  assign count_next_s = fifo_count_s + FCNT_W'(fifo_push_s) - FCNT_W'(fifo_pop_s);

  // TX push arbitration: stop-marker push or CPU UART write, never both.
  always_comb begin
    fifo_push_s = 1'b0;
    fifo_din_s  = cpu_dout;
    drop_s      = 1'b0;
    if (state_r == STOP_PUSH) begin
      fifo_push_s = space_s;
      fifo_din_s  = 8'h00;
    end else if ((state_r == RUN) && cpu_wr && uart_sel_s && (cpu_dout != 8'h00)) begin
      fifo_push_s = space_s;
      drop_s      = !space_s;
    end else begin
      fifo_push_s = 1'b0;
    end
  end

  // Read data mux for RAM and the IO window.
  always_comb begin
    rd_data_s = 8'h00;
    if (!io_s) begin
      rd_data_s = ram_r[ram_addr_s];
    end else if (uart_sel_s) begin
      rd_data_s = rx_valid ? rx_data : 8'h00;
    end else if (clk_grp_s) begin
      rd_data_s = (addr_s[1:0] == 2'b00) ? counter_r[7:0]
                                          : snap_byte(32'(snapshot_r), addr_s[1:0]);
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (cpu_wr && !io_s) begin
      ram_r[ram_addr_s] <= cpu_dout;
    end
  end

  // Bus read register, counter/snapshot and TX status flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din        <= 8'h00;
      counter_r      <= '0;
      snapshot_r     <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      counter_r <= counter_r + CNT_W'(1);
      if (!cpu_wr) begin
        cpu_din <= rd_data_s;
      end
      if (!cpu_wr && clk_sel_s) begin
        snapshot_r <= counter_r;
      end
      io_buffer_full <= (count_next_s >= FCNT_W'(TX_DEPTH - 1));
      if (drop_s) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // Program-stop sequence: queue a 0x00 marker, wait for the FIFO to drain, then halt.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= RUN;
      halted  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (cpu_wr && clk_sel_s) begin
            state_r <= STOP_PUSH;
          end
        end
        STOP_PUSH: begin
          if (space_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty_s) begin
            state_r <= HALTED;
            halted  <= 1'b1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized bench for mem_io_responder with a queue-based reference model.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_overflow;
  logic        halted;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] cnt_model;
  logic [7:0]  seen_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  ram_model[int];

  localparam logic [31:0] UART = 32'h0003_0000;
  localparam logic [31:0] CLKA = 32'h0003_0004;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_overflow    (tx_overflow),
    .halted         (halted)
  );

  always #5 clk_in = ~clk_in;

  // Record every byte the transmitter accepts at the coming edge.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) seen_q.push_back(tx_data);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cnt_model++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cpu_wr = 1'b0;
    cpu_a  = 32'h0;
    tick();
    rst_in    = 1'b0;
    cnt_model = 32'h0;
    seen_q.delete();
    exp_q.delete();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a    = a;
    cpu_wr   = 1'b1;
    cpu_dout = d;
    tick();
    cpu_wr = 1'b0;
    cpu_a  = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
    cpu_a  = a;
    cpu_wr = 1'b0;
    tick();
    chk(tag, {24'h0, cpu_din}, {24'h0, exp});
    cpu_a = 32'h0;
  endtask

  task automatic chk_seen(input string tag);
    chk({tag, "_len"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {24'h0, (i < seen_q.size()) ? seen_q[i] : 8'hxx}, {24'h0, exp_q[i]});
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  keep;
    logic [31:0] snap;
    int          occ;
    logic        ovf;
    logic        wr;
    logic        rdy;
    logic        pop;
    logic        push;
    int          n;

    rst_in = 1'b1; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; cnt_model = 32'h0;
    tick();
    tick();
    chk("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_overflow", {31'h0, tx_overflow}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_ibf", {31'h0, io_buffer_full}, 32'h0);
    chk("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
    do_reset();
    rd_chk("snap_after_rst", 32'h0003_0007, 8'h00);

    // RAM directed cases.
    bus_wr(32'h0000_0123, 8'hA5);
    rd_chk("ram_123", 32'h0000_0123, 8'hA5);
    bus_wr(32'h0001_FFFF, 8'h5A);
    rd_chk("ram_1ffff", 32'h0001_FFFF, 8'h5A);
    ram_model[32'h123]   = 8'hA5;
    ram_model[32'h1FFFF] = 8'h5A;

    // Random RAM writes; cpu_din must hold across write cycles.
    rd_chk("ram_keep_rd", 32'h0000_0123, 8'hA5);
    keep = 8'hA5;
    for (int i = 0; i < 48; i++) begin
      a = $urandom_range(0, 32'h1FFFF);
      d = 8'($urandom);
      ram_model[a] = d;
      bus_wr(a, d);
      chk("ram_wr_hold", {24'h0, cpu_din}, {24'h0, keep});
    end
    foreach (ram_model[k]) rd_chk("ram_rand", k, ram_model[k]);

    // RX path.
    rx_valid = 1'b1; rx_data = 8'h7E; cpu_a = UART; cpu_wr = 1'b0;
    #1 chk("rx_pop_hi", {31'h0, rx_pop}, 32'h1);
    tick();
    chk("rx_data", {24'h0, cpu_din}, 32'h7E);
    cpu_a = 32'h0;
    #1 chk("rx_pop_off_addr", {31'h0, rx_pop}, 32'h0);
    rx_valid = 1'b0; cpu_a = UART;
    #1 chk("rx_pop_novalid", {31'h0, rx_pop}, 32'h0);
    tick();
    chk("rx_empty_data", {24'h0, cpu_din}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      cpu_a    = UART;
      #1 chk("rx_rand_pop", {31'h0, rx_pop}, {31'h0, rx_valid});
      tick();
      chk("rx_rand_data", {24'h0, cpu_din}, {24'h0, rx_valid ? rx_data : 8'h00});
    end
    rx_valid = 1'b0; cpu_a = 32'h0;

    // Undefined IO addresses.
    bus_wr(32'h0003_0010, 8'hEE);
    rd_chk("io_undef_10", 32'h0003_0010, 8'h00);
    rd_chk("io_undef_08", 32'h0003_0008, 8'h00);

    // Counter snapshot coherence.
    do_reset();
    repeat (32'h1234) tick();
    snap = cnt_model;
    rd_chk("cnt_b0", CLKA, snap[7:0]);
    rd_chk("cnt_b1", 32'h0003_0005, snap[15:8]);
    rd_chk("cnt_b2", 32'h0003_0006, snap[23:16]);
    rd_chk("cnt_b3", 32'h0003_0007, snap[31:24]);
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 900)) tick();
      snap = cnt_model;
      rd_chk("cnt_r0", CLKA, snap[7:0]);
      rd_chk("cnt_r1", 32'h0003_0005, snap[15:8]);
      rd_chk("cnt_r2", 32'h0003_0006, snap[23:16]);
      rd_chk("cnt_r3", 32'h0003_0007, snap[31:24]);
    end

    // TX "H", 0x00, "i" with the transmitter ready.
    do_reset();
    tx_ready = 1'b1;
    bus_wr(UART, 8'h48);
    bus_wr(UART, 8'h00);
    bus_wr(UART, 8'h69);
    repeat (5) tick();
    exp_q = '{8'h48, 8'h69};
    chk_seen("tx_hi");
    chk("tx_hi_ovf", {31'h0, tx_overflow}, 32'h0);

    // Backpressure: fill, overflow, then drain.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(1, 255));
      if (i < 8) exp_q.push_back(d);
      bus_wr(UART, d);
      if (i == 5) chk("bp_ibf_6", {31'h0, io_buffer_full}, 32'h0);
      if (i == 6) chk("bp_ibf_7", {31'h0, io_buffer_full}, 32'h1);
      if (i == 7) chk("bp_ovf_8", {31'h0, tx_overflow}, 32'h0);
      if (i == 8) chk("bp_ovf_9", {31'h0, tx_overflow}, 32'h1);
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_ibf_cnt7", {31'h0, io_buffer_full}, 32'h1);
    tick();
    chk("bp_ibf_cnt6", {31'h0, io_buffer_full}, 32'h0);
    repeat (10) tick();
    chk_seen("bp_drain");

    // Randomized TX traffic against an occupancy model.
    do_reset();
    occ = 0; ovf = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 9) < 4);
      wr  = 1'($urandom);
      d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tx_ready = rdy;
      cpu_wr   = wr;
      cpu_dout = d;
      cpu_a    = wr ? UART : 32'($urandom_range(0, 32'h1FFFF));
      pop  = rdy && (occ > 0);
      push = wr && (d != 8'h00) && ((occ < 8) || pop);
      if (wr && (d != 8'h00) && !push) ovf = 1'b1;
      if (push) exp_q.push_back(d);
      occ = occ + int'(push) - int'(pop);
      tick();
      chk("rnd_ibf", {31'h0, io_buffer_full}, {31'h0, occ >= 7});
      chk("rnd_valid", {31'h0, tx_valid}, {31'h0, occ != 0});
      chk("rnd_ovf", {31'h0, tx_overflow}, {31'h0, ovf});
    end
    cpu_wr = 1'b0; cpu_a = 32'h0; tx_ready = 1'b1;
    repeat (12) tick();
    chk_seen("rnd_stream");

    // Stop sequence with a partly filled FIFO.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus_wr(UART, d);
    end
    exp_q.push_back(8'h00);
    bus_wr(CLKA, 8'($urandom));
    repeat (4) tick();
    chk("stop_not_halted", {31'h0, halted}, 32'h0);
    bus_wr(UART, 8'h55);
    chk("stop_ignored_ovf", {31'h0, tx_overflow}, 32'h0);
    tx_ready = 1'b1;
    n = 0;
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    chk("stop_halted", {31'h0, halted}, 32'h1);
    chk_seen("stop_stream");
    bus_wr(UART, 8'h77);
    repeat (5) tick();
    chk("halt_no_tx", seen_q.size(), 32'd4);
    chk("halt_valid", {31'h0, tx_valid}, 32'h0);
    bus_wr(32'h0000_4242, 8'hC3);
    rd_chk("halt_ram", 32'h0000_4242, 8'hC3);
    do_reset();
    chk("rerun_halted", {31'h0, halted}, 32'h0);
    bus_wr(UART, 8'h31);
    repeat (3) tick();
    exp_q = '{8'h31};
    chk_seen("rerun_tx");

    // Stop issued while the FIFO is completely full.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(1, 255));
      exp_q.push_back(d);
      bus_wr(UART, d);
    end
    exp_q.push_back(8'h00);
    bus_wr(CLKA, 8'h01);
    repeat (6) tick();
    chk("full_stop_wait", {31'h0, halted}, 32'h0);
    chk("full_stop_ovf", {31'h0, tx_overflow}, 32'h0);
    tx_ready = 1'b1;
    n = 0;
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    chk("full_stop_halted", {31'h0, halted}, 32'h1);
    chk_seen("full_stop_stream");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus.
- Serves 128 KB RAM reads and writes, plus the memory-mapped I/O window at 0x30000 (mem_a[17:16]==2'b11).
- Owns the UART TX buffer (drives io_buffer_full back to the CPU), the RX byte path, the free-running clock counter and the program-stop sequence.
- Sits between the cpu top and the board UART/RAM.

Parameters:
- RAM_ADDR_W, 17, byte address width of RAM; size 2^17 = 128 KB.
- TX_DEPTH, 8, UART TX FIFO depth in bytes (power of two, >=4).
- CNT_W, 32, clock counter width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- cpu_a  in  32  address from CPU; only [17:0] decoded
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU, registered
- io_buffer_full  out  1  TX buffer almost full; CPU must not write 0x30000
- rx_data  in  8  UART received byte
- rx_valid  in  1  rx_data holds an unread byte
- rx_pop  out  1  consume rx_data this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- tx_overflow  out  1  sticky: a TX write was dropped
- halted  out  1  program stop complete

Behaviour:
- Reset (rst_in=1 at posedge) clears all outputs:
  - cpu_din=0, rx_pop=0, tx_valid=0, tx_overflow=0, halted=0, io_buffer_full=0.
  - FIFO empty, counter=0, FSM=RUN.
  - RAM contents are not cleared.
  - Reset mid-drain abandons queued bytes.
- Decode: io = (cpu_a[17:16]==2'b11); otherwise RAM at cpu_a[RAM_ADDR_W-1:0].
- RAM read: cpu_din <= ram[a] at the posedge; data is valid the cycle after the address is presented (1-cycle latency).
- RAM write: ram[a] <= cpu_dout at the posedge; no wait. cpu_din is unchanged on write cycles.
- Read 0x30000:
  - cpu_din <= rx_valid ? rx_data : 0.
  - rx_pop is combinational, =1 in the same cycle iff read && addr==0x30000 && rx_valid.
  - One pop per cycle the address is held; the CPU issues each read address once.
- Read 0x30004..0x30007:
  - Reading 0x30004 latches snapshot <= counter and returns counter[7:0].
  - 0x30005/6/7 return snapshot bytes 1/2/3 (little-endian), so a 4-byte read is coherent.
- Other IO reads return 0. Writes to undefined IO addresses are ignored.
- Counter: +1 every cycle after reset, wraps modulo 2^CNT_W.
- Write 0x30000 (FSM=RUN):
  - cpu_dout==0 is ignored.
  - Otherwise push to the TX FIFO if count<TX_DEPTH, or if count==TX_DEPTH and a pop occurs in the same cycle.
  - Otherwise drop and set tx_overflow.
- io_buffer_full = (count >= TX_DEPTH-1), registered from the next-state count. This covers the one-cycle decision lag in the CPU.
- TX side:
  - tx_valid = FIFO non-empty; tx_data = FIFO head.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo TX_DEPTH.
- Stop FSM:
  - RUN: a write to 0x30004 (any data) -> STOP_PUSH.
  - STOP_PUSH: push 0x00 when space is available (same rule as normal pushes) -> DRAIN; stays while full.
  - DRAIN: wait for FIFO empty -> HALTED.
  - HALTED: halted=1; absorbing until reset.
  - In every non-RUN state, CPU writes to 0x30000/0x30004 are ignored and do not set overflow. RAM and reads stay functional.
- A CPU write to 0x30000 in the same cycle as the transition to STOP_PUSH is processed first (RUN rules apply to that cycle).

Decomposition:
- Package mem_io_pkg:
  - IO_UART_ADDR = 18'h30000, IO_CLK_ADDR = 18'h30004.
  - IO region select bits 2'b11.
  - stop_state_t enum {RUN, STOP_PUSH, DRAIN, HALTED}.
- Sub-module sync_fifo: width 8, depth TX_DEPTH.
  - Ports: push/pop/din/dout/count/empty/full.
  - Same clk_in/rst_in.
- The RAM array, decode, counter and FSM stay in the top.

Test Plan:
- RAM: write 0xA5 to 0x00123, then read 0x00123 -> cpu_din==0xA5 on the following cycle. Read of 0x1FFFF after writing 0x5A returns 0x5A.
- TX: write 'H'(0x48), 0x00, 'i'(0x69) to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only; tx_overflow=0.
- Backpressure: tx_ready=0, write 7 bytes -> io_buffer_full=1 after the 7th. 8th accepted, 9th dropped, tx_overflow=1. Release tx_ready -> exactly 8 bytes out in order, and io_buffer_full clears when count<7.
- Counter: release reset, wait 0x1234 cycles, read 0x30004..0x30007 over 4 cycles -> bytes form the value latched at the 0x30004 read (low byte 0x34 ±issue offset), upper bytes consistent despite increments.
- RX: rx_valid=1, rx_data=0x7E, read 0x30000 -> rx_pop=1 for one cycle, cpu_din=0x7E. With rx_valid=0 -> cpu_din=0, rx_pop=0.
- Stop: queue 3 bytes with tx_ready=0, write 0x30004 -> halted=0 until 3 bytes plus 0x00 are transmitted, then halted=1. A later 0x30000 write is not emitted. Reset -> halted=0, FSM=RUN.
